ram_stream_reader: RTL
======================

Name: ram_stream_reader

Overview:
Read-side sequencer for the team's two-port RAM. It drives the RAM's read-address port, captures the combinational read data and emits a burst of words on a valid/ready output stream. One start command reads LENGTH consecutive words beginning at a start address, with address wrap-around. It sits between the RAM's read port and any downstream stream consumer. A separate writer owns the RAM's write port.

Parameters:
ADDR_WIDTH, 3, RAM address width; the RAM depth is 2**ADDR_WIDTH.
DATA_WIDTH, 8, RAM word width.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  command strobe; sampled only in IDLE
start_addr  input  ADDR_WIDTH  first word address
length  input  ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when the burst completes
r_addr  output  ADDR_WIDTH  to the RAM read address
r_data  input  DATA_WIDTH  from the RAM read data (combinational, same cycle)
m_data  output  DATA_WIDTH  stream data
m_valid  output  1  stream valid
m_ready  input  1  stream ready from the consumer
m_last  output  1  marks the final word of a burst; qualified by m_valid

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE.
  - busy, done, m_valid and m_last are 0.
  - m_data=0, r_addr=0, internal address=0, remaining=0.
- The r_addr output is the internal address register, and r_data is used only in the capture cycle.
- States: IDLE, STREAM, DRAIN.
- IDLE:
  - start=1 with length!=0: addr<=start_addr, remaining<=length, go to STREAM.
  - start=1 with length==0: no stream beats; done pulses the next cycle; stay in IDLE.
- STREAM:
  - The output slot is free when m_valid==0 or m_ready==1.
  - When the slot is free, the block performs a capture on the clock edge:
    - m_data<=r_data, m_valid<=1, m_last<=(remaining==1).
    - addr<=addr+1 modulo 2**ADDR_WIDTH (the wrap from the top address to 0 is silent).
    - remaining<=remaining-1.
  - A capture with remaining==1 moves the state to DRAIN.
  - When the slot is not free, m_data, m_valid, m_last and addr all hold.
- DRAIN:
  - When m_valid and m_ready are both high: m_valid<=0, m_last<=0, done<=1 for one cycle, go to IDLE.
- Latency and throughput:
  - The first m_valid appears 2 cycles after start is sampled (edge 1 enters STREAM, edge 2 captures).
  - With m_ready held at 1, the block sustains one word per cycle.
  - A LENGTH-word burst finishes with its done pulse at cycle LENGTH+2.
- Handshake rules:
  - While m_valid=1 and m_ready=0, m_data and m_last are stable.
  - m_valid never drops without a transfer, except on reset.
- start while busy=1 is ignored: it is not queued and has no effect.
- length==2**ADDR_WIDTH reads every location exactly once, starting at start_addr.
- Concurrent RAM write to the address being read: the captured word is the value r_data presents at the capture edge. Write-through is defined by the RAM, not by this block.
- Reset mid-burst: outputs return to their reset values immediately, with no done pulse and no further beats.
- done is driven by a register. A new start can be accepted in the same cycle that done is high (the block is in IDLE).

Optional Feature:
Macro RAM_STREAM_READER_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt, 16 bits wide.
  - The counter clears to 0 on an accepted start and on reset.
  - It increments on each cycle with m_valid=1 and m_ready=0.
  - It saturates at 16'hFFFF and holds its value after done.
- Not defined: the port and the counter logic do not exist. All other behaviour is identical in both builds.

Test Plan:
- RAM preloaded with word i = 8'h10+i; start_addr=2, length=3, m_ready=1 -> m_data 12,13,14 on consecutive cycles; m_last only on 14; done 1 cycle after the last beat; busy low afterwards.
- start_addr=6, length=4 (ADDR_WIDTH=3) -> r_addr sequence 6,7,0,1; data 16,17,10,11; m_last on 11.
- length=8, start_addr=0, m_ready toggling 1,0,0,1,... -> all 8 words delivered in order; m_data stable while stalled; with the macro defined, stall_cnt equals the number of valid&&!ready cycles.
- length=0 start -> no m_valid; done pulses exactly once; busy stays 0.
- Second start asserted mid-burst (start_addr=5, length=2) -> ignored; the original burst completes unchanged, with only one done pulse.
- rst_n asserted low during the 3rd beat of a length=6 burst -> m_valid, busy and done go to 0 immediately. After release, a new start (start_addr=1, length=1) yields a single beat 8'h11 with m_last=1.

Source files
------------

// File: rtl/ram_stream_reader.sv
// Burst read sequencer: walks RAM read addresses and streams words out on valid/ready.
// Optional stall counter port enabled by RAM_STREAM_READER_STALL_CNT_EN.
module ram_stream_reader #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] r_addr,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
`ifdef RAM_STREAM_READER_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] LEN_ONE = 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic                  done_q, done_d;
    logic                  slot_free;

    assign slot_free = !m_valid_q || m_ready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        addr_d  = start_addr;
                        rem_d   = length;
                        state_d = STREAM;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                // Capture whenever the previous beat has left or never existed.
                if (slot_free) begin
                    m_data_d  = r_data;
                    m_valid_d = 1'b1;
                    m_last_d  = (rem_q == LEN_ONE);
                    addr_d    = addr_q + 1'b1;
                    rem_d     = rem_q - 1'b1;
                    if (rem_q == LEN_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign r_addr  = addr_q;
    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;

`ifdef RAM_STREAM_READER_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == IDLE && start) begin
            stall_d = '0;
        end else if (m_valid_q && !m_ready && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
